switch_debouncer: RTL and testbench

- Input-side conditioner for the dev-kit slide switches and push buttons; it produces the clean logic levels that downstream gate and LED logic consume.
- Each of N raw asynchronous inputs is synchronized, then debounced with a per-channel stability counter.
- Outputs per channel: a debounced level plus single-cycle rise and fall pulses.
- An 8-bit wrap-around counter tallies channel-0 rising events for display.

---
 rtl/switch_debouncer_if.sv | 20 ++
 rtl/switch_debouncer.sv | 95 +++++++++
 tb/tb_switch_debouncer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/switch_debouncer_if.sv
// rtl/switch_debouncer_if.sv - raw switch inputs and conditioned outputs of the debouncer
interface switch_debouncer_if #(
  parameter int N = 4
);
  logic [N-1:0] raw_in;
  logic [N-1:0] db_out;
  logic [N-1:0] rise_pulse;
  logic [N-1:0] fall_pulse;
  logic [7:0]   rise_count;

  modport master (
    output raw_in,
    input  db_out, rise_pulse, fall_pulse, rise_count
  );

  modport slave (
    input  raw_in,
    output db_out, rise_pulse, fall_pulse, rise_count
  );
endinterface

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - two-flop synchronizer plus per-channel stability-count debouncer
module switch_debouncer #(
  parameter int N             = 4,
  parameter int CNT_W         = 20,
  parameter int STABLE_CYCLES = 500000
) (
  input logic            clk,
  input logic            rst,
  switch_debouncer_if.slave sw
);

  typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [N-1:0]     s1, s2;
  logic [N-1:0]     db, rise, fall;
  logic [7:0]       rise_count;
  state_t           state [N];
  logic [CNT_W-1:0] cnt   [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= '0;
      s2         <= '0;
      db         <= '0;
      rise       <= '0;
      fall       <= '0;
      rise_count <= '0;
      for (int i = 0; i < N; i++) begin
        state[i] <= STABLE_LO;
        cnt[i]   <= '0;
      end
    end else begin
      s1   <= sw.raw_in;
      s2   <= s1;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < N; i++) begin
        case (state[i])
          STABLE_LO: begin
            if (s2[i]) begin
              state[i] <= WAIT_HI;
              cnt[i]   <= ONE;
            end
          end
          WAIT_HI: begin
            // A single low sample throws away the whole run; counts never accumulate across bounces.
            if (!s2[i]) begin
              state[i] <= STABLE_LO;
              cnt[i]   <= '0;
            end else if (cnt[i] == LIMIT) begin
              state[i] <= STABLE_HI;
              db[i]    <= 1'b1;
              rise[i]  <= 1'b1;
              cnt[i]   <= '0;
            end else begin
              cnt[i] <= cnt[i] + ONE;
            end
          end
          STABLE_HI: begin
            if (!s2[i]) begin
              state[i] <= WAIT_LO;
              cnt[i]   <= ONE;
            end
          end
          WAIT_LO: begin
            if (s2[i]) begin
              state[i] <= STABLE_HI;
              cnt[i]   <= '0;
            end else if (cnt[i] == LIMIT) begin
              state[i] <= STABLE_LO;
              db[i]    <= 1'b0;
              fall[i]  <= 1'b1;
              cnt[i]   <= '0;
            end else begin
              cnt[i] <= cnt[i] + ONE;
            end
          end
        endcase
      end
      // Same condition that raises rise[0], so the tally lands on the pulse edge.
      if (state[0] == WAIT_HI && s2[0] && cnt[0] == LIMIT) begin
        rise_count <= rise_count + 8'd1;
      end
    end
  end

  assign sw.db_out     = db;
  assign sw.rise_pulse = rise;
  assign sw.fall_pulse = fall;
  assign sw.rise_count = rise_count;

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - scoreboard bench for switch_debouncer against a sliding-window level model
module tb_switch_debouncer;
  localparam int N     = 4;
  localparam int CNT_W = 3;
  localparam int S     = 4;

  typedef struct packed {
    logic [N-1:0] db;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [7:0]   cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  switch_debouncer_if #(.N(N)) sw ();

  switch_debouncer #(.N(N), .CNT_W(CNT_W), .STABLE_CYCLES(S)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw)
  );

  exp_t         exp_q[$];
  int           vectors     = 0;
  int           miscompares = 0;
  int           rise0_seen  = 0;
  int           fall0_seen  = 0;

  // Model state: recent raw samples (newest last) and the accepted levels.
  logic [N-1:0] hist[$];
  logic [N-1:0] m_db  = '0;
  logic [7:0]   m_cnt = '0;
  logic [N-1:0] cur   = '0;

  // A level is accepted once raw was sampled at that level for S+1 consecutive
  // edges; the decision appears two edges after the last of those samples.
  function automatic exp_t model_step(input logic [N-1:0] r, input logic rs);
    exp_t e;
    logic [N-1:0] all1, all0, nd;
    if (rs) begin
      foreach (hist[k]) hist[k] = '0;
      m_db = '0;
      m_cnt = '0;
      e.db = '0; e.rise = '0; e.fall = '0; e.cnt = '0;
      return e;
    end
    hist.push_back(r);
    void'(hist.pop_front());
    all1 = '1;
    all0 = '1;
    for (int k = hist.size() - S - 3; k <= hist.size() - 3; k++) begin
      all1 &= hist[k];
      all0 &= ~hist[k];
    end
    nd = (m_db | all1) & ~all0;
    e.rise = nd & ~m_db;
    e.fall = m_db & ~nd;
    if (e.rise[0]) m_cnt = m_cnt + 8'd1;
    m_db = nd;
    e.db = nd;
    e.cnt = m_cnt;
    return e;
  endfunction

  task automatic step(input logic [N-1:0] r, input logic rs);
    @(negedge clk);
    sw.raw_in = r;
    rst = rs;
    exp_q.push_back(model_step(r, rs));
  endtask

  task automatic hold(input logic [N-1:0] r, input int n);
    cur = r;
    for (int k = 0; k < n; k++) step(r, 1'b0);
  endtask

  task automatic set_bit(input int ch, input logic v, input int n);
    cur[ch] = v;
    hold(cur, n);
  endtask

  task automatic check_int(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: one registered output word per clock, compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sw.rise_pulse[0] === 1'b1) rise0_seen++;
      if (sw.fall_pulse[0] === 1'b1) fall0_seen++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ({sw.db_out, sw.rise_pulse, sw.fall_pulse, sw.rise_count} !== e) begin
          miscompares++;
          $display("FAIL vec%0d @%0t: db=%b rise=%b fall=%b count=%0d, expected db=%b rise=%b fall=%b count=%0d",
                   vectors, $time, sw.db_out, sw.rise_pulse, sw.fall_pulse, sw.rise_count,
                   e.db, e.rise, e.fall, e.cnt);
        end
      end
    end
  end

  initial begin
    int r0, f0, g;
    logic [N-1:0] rv;
    sw.raw_in = '0;
    for (int k = 0; k < S + 3; k++) hist.push_back('0);

    // Reset held with all inputs high, then released.
    for (int k = 0; k < 3; k++) step(4'b1111, 1'b1);
    cur = 4'b1111;
    hold(cur, 10);

    // Clean low then high on channel 0.
    set_bit(0, 1'b0, 10);
    set_bit(0, 1'b1, 10);

    // Channel 1 bounces that must be rejected, then a held level that is accepted.
    set_bit(1, 1'b0, 10);
    set_bit(1, 1'b1, 2); set_bit(1, 1'b0, 1);
    set_bit(1, 1'b1, 1); set_bit(1, 1'b0, 1);
    set_bit(1, 1'b1, 3); set_bit(1, 1'b0, 10);
    set_bit(1, 1'b1, 2); set_bit(1, 1'b0, 1);
    set_bit(1, 1'b1, 1); set_bit(1, 1'b0, 1);
    set_bit(1, 1'b1, 10);

    // Channel 2 fall.
    set_bit(2, 1'b0, 10);

    // 256 press/release cycles on channel 0.
    r0 = rise0_seen;
    f0 = fall0_seen;
    for (int k = 0; k < 256; k++) begin
      set_bit(0, 1'b0, $urandom_range(6, 10));
      set_bit(0, 1'b1, $urandom_range(6, 10));
    end
    hold(cur, 10);
    check_int("ch0_rise_pulses", rise0_seen - r0, 256);
    check_int("ch0_fall_pulses", fall0_seen - f0, 256);

    // Channel 3 rises on the same edge channel 2 falls, then reset lands mid-wait.
    set_bit(2, 1'b1, 10);
    set_bit(3, 1'b0, 10);
    cur[3] = 1'b1;
    cur[2] = 1'b0;
    hold(cur, 10);
    cur[2] = 1'b1;
    cur[3] = 1'b0;
    hold(cur, 10);
    cur[3] = 1'b1;
    hold(cur, 3);
    step(cur, 1'b1);
    step(cur, 1'b1);
    hold(cur, 12);

    // Random segments with bounces and occasional resets.
    for (int k = 0; k < 300; k++) begin
      g = $urandom_range(0, 39);
      if (g == 0) begin
        for (int j = 0; j < $urandom_range(1, 2); j++) step(cur, 1'b1);
      end else begin
        rv = N'($urandom);
        hold(rv, $urandom_range(1, 8));
      end
    end
    hold(cur, 10);

    @(posedge clk);
    #2;
    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
